// File: rtl/axi_line_reader_pkg.sv
// Shared AXI encodings and cache geometry used by the line-refill engine
// and its neighbours on the data-cache side.
package axi_line_reader_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int DCACHE_LINE_SIZE = 16;

endpackage

// File: rtl/axi_read_if.sv
// AXI4 read address and read data channels (AR + R).
interface axi_read_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (output arvalid, araddr, arlen, arsize, arburst, rready,
                  input  arready, rvalid, rdata, rresp, rlast);
  modport slave  (input  arvalid, araddr, arlen, arsize, arburst, rready,
                  output arready, rvalid, rdata, rresp, rlast);
endinterface

// File: rtl/axi_read_master_if.sv
// Cache-side line-fetch request/response port of the refill engine.
interface axi_read_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  logic                    read_req_valid;
  logic [ADDR_WIDTH-1:0]   read_addr;
  logic                    read_resp_valid;
  logic [LINE_BYTES*8-1:0] read_data;
  logic                    read_err;

  // self: the refill engine; master: the cache core issuing fetches
  modport self   (input  read_req_valid, read_addr,
                  output read_resp_valid, read_data, read_err);
  modport master (output read_req_valid, read_addr,
                  input  read_resp_valid, read_data, read_err);
endinterface

// File: rtl/axi_line_reader.sv
// Cache line refill engine: one line-fetch request becomes one AXI4 INCR
// burst whose beats are assembled into a line returned with a one-cycle pulse.
module axi_line_reader
  import axi_line_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = DCACHE_LINE_SIZE
) (
  input logic             clk,
  input logic             rst_n,
  axi_read_master_if.self req_if,
  axi_read_if.master      axi_if
);

  localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]      BEATS_C  = CNT_W'(BEATS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [2:0]            ARSIZE   = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  err_q,   err_d;
  logic [DATA_WIDTH-1:0] line_q [BEATS];
  logic [DATA_WIDTH-1:0] line_d [BEATS];

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    line_d  = line_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_if.read_req_valid) begin
          addr_d  = req_if.read_addr & ~OFF_MASK;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (axi_if.arready) state_d = S_DATA;
      end

      S_DATA: begin
        if (axi_if.rvalid) begin
          // The counter saturates at BEATS so surplus beats stay detectable.
          if (cnt_q < BEATS_C) begin
            line_d[cnt_q[IDX_W-1:0]] = axi_if.rdata;
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (axi_if.rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (axi_if.rlast) begin
            if (cnt_q != BEATS_C - 1'b1) err_d = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the line buffer is deliberately left out of reset; its content is
  // only consumed alongside read_resp_valid, which always follows a refill.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign axi_if.arvalid = (state_q == S_ADDR);
  assign axi_if.araddr  = addr_q;
  assign axi_if.arlen   = 8'(BEATS - 1);
  assign axi_if.arsize  = ARSIZE;
  assign axi_if.arburst = AXI_BURST_INCR;
  assign axi_if.rready  = (state_q == S_DATA);

  assign req_if.read_resp_valid = (state_q == S_RESP);
  assign req_if.read_err        = (state_q == S_RESP) && err_q;

  for (genvar i = 0; i < BEATS; i++) begin : g_line_out
    assign req_if.read_data[i*DATA_WIDTH +: DATA_WIDTH] = line_q[i];
  end

endmodule

// File: tb/tb_axi_line_reader.sv
// Self-checking bench for axi_line_reader: a scoreboard of expected lines
// filled as beats are driven and drained by a response monitor.
module tb_axi_line_reader;
  import axi_line_reader_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LB    = 16;
  localparam int BEATS = LB * 8 / DW;
  localparam int LW    = LB * 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_read_master_if #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) req_if ();
  axi_read_if        #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

  axi_line_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BYTES(LB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (req_if.self),
    .axi_if (axi_if.master)
  );

  typedef struct packed {
    logic [LW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  int ar_cnt   = 0;
  int req_cyc  = 0;
  int last_resp_cyc = 0;

  logic [DW-1:0] model_line [BEATS];
  int            model_cnt = 0;
  logic          model_err = 1'b0;

  logic          prev_arvalid = 1'b0;
  logic [AW-1:0] prev_araddr  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: drains the scoreboard and watches channel invariants.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_arvalid = 1'b0;
    end else begin
      if (axi_if.arvalid && axi_if.arready) ar_cnt++;
      if (axi_if.arvalid && prev_arvalid) begin
        checks++;
        if (axi_if.araddr !== prev_araddr) begin
          failures++;
          $display("FAIL araddr_stable: got %h was %h while arvalid high", axi_if.araddr, prev_araddr);
        end
      end
      prev_arvalid = axi_if.arvalid;
      prev_araddr  = axi_if.araddr;
      if (req_if.read_resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        checks++;
        if (axi_if.arvalid !== 1'b0 || axi_if.rready !== 1'b0) begin
          failures++;
          $display("FAIL resp_overlap: arvalid=%b rready=%b required 0 0", axi_if.arvalid, axi_if.rready);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got a response, required none");
        end else begin
          e = exp_q.pop_front();
          if (req_if.read_data !== e.data) begin
            failures++;
            $display("FAIL resp_data: got %h required %h", req_if.read_data, e.data);
          end
          checks++;
          if (req_if.read_err !== e.err) begin
            failures++;
            $display("FAIL resp_err: got %b required %b", req_if.read_err, e.err);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_req(input logic [AW-1:0] a);
    req_if.read_req_valid = 1'b1;
    req_if.read_addr      = a;
    tick();
    req_cyc               = cyc;
    req_if.read_req_valid = 1'b0;
    model_cnt             = 0;
    model_err             = 1'b0;
  endtask

  task automatic ar_phase(input logic [AW-1:0] exp_addr, input int delay);
    int n = 0;
    while (axi_if.arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (axi_if.arvalid !== 1'b1) begin
      failures++;
      $display("FAIL ar_wait: arvalid=%b required 1 within 20 cycles", axi_if.arvalid);
      return;
    end
    tick(delay);
    checks++;
    if (axi_if.araddr !== exp_addr) begin
      failures++;
      $display("FAIL araddr: got %h required %h", axi_if.araddr, exp_addr);
    end
    checks++;
    if ({axi_if.arlen, axi_if.arsize, axi_if.arburst} !== {8'd3, 3'd2, 2'b01}) begin
      failures++;
      $display("FAIL ar_attrs: got len=%0d size=%0d burst=%b required 3 2 01",
               axi_if.arlen, axi_if.arsize, axi_if.arburst);
    end
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] rr, input logic last);
    int n = 0;
    int idx;
    logic [LW-1:0] line;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = d;
    axi_if.rresp  = rr;
    axi_if.rlast  = last;
    while (axi_if.rready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (axi_if.rready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL r_wait: rready=%b required 1 within 20 cycles", axi_if.rready);
      axi_if.rvalid = 1'b0;
      axi_if.rlast  = 1'b0;
      return;
    end
    idx = model_cnt;
    if (idx < BEATS) begin
      model_line[idx] = d;
      model_cnt++;
    end else begin
      model_err = 1'b1;
    end
    if (rr != AXI_RESP_OKAY) model_err = 1'b1;
    if (last) begin
      if (idx != BEATS - 1) model_err = 1'b1;
      for (int i = 0; i < BEATS; i++) line[i*DW +: DW] = model_line[i];
      exp_q.push_back('{data: line, err: model_err});
    end
    tick();
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
  endtask

  task automatic burst(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                       input logic [DW-1:0] seed, input int nbeats, input int bad_beat,
                       input int ar_delay, input int gap);
    send_req(addr);
    ar_phase(exp_addr, ar_delay);
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) tick(gap);
      send_beat(DW'(seed * (i + 1)), (i == bad_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY,
                i == nbeats - 1);
    end
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (resp_cnt < target) begin
      failures++;
      $display("FAIL resp_wait: resp_cnt=%0d required %0d within 20 cycles", resp_cnt, target);
    end
  endtask

  task automatic test_reset();
    req_if.read_req_valid = 1'b0;
    req_if.read_addr      = '0;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = '0;
    axi_if.rresp   = 2'b00;
    axi_if.rlast   = 1'b0;
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ({axi_if.arvalid, axi_if.rready, req_if.read_resp_valid, req_if.read_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got arvalid,rready,resp,err=%b required 0000",
               {axi_if.arvalid, axi_if.rready, req_if.read_resp_valid, req_if.read_err});
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (axi_if.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_ar: arvalid=%b required 0", axi_if.arvalid);
    end
  endtask

  task automatic test_basic();
    int r0 = resp_cnt;
    burst(32'h0000_1234, 32'h0000_1230, 32'h1111_1111, 4, -1, 0, 0);
    wait_resp(r0 + 1);
    // Request sampled at edge T; response high in the cycle sampled at T+6.
    checks++;
    if (last_resp_cyc - req_cyc !== BEATS + 1) begin
      failures++;
      $display("FAIL resp_latency: got %0d cycles required %0d", last_resp_cyc - req_cyc, BEATS + 1);
    end
  endtask

  task automatic test_backpressure();
    int r0 = resp_cnt;
    burst(32'h2000_004C, 32'h2000_0040, 32'h1111_1111, 4, -1, 3, 2);
    wait_resp(r0 + 1);
    tick(4);
    checks++;
    if (resp_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL bp_single_resp: got %0d pulses required 1", resp_cnt - r0);
    end
  endtask

  task automatic test_error_resp();
    int r0 = resp_cnt;
    burst(32'h0000_8000, 32'h0000_8000, 32'h0101_0101, 4, 2, 0, 1);
    wait_resp(r0 + 1);
  endtask

  task automatic test_length_mismatch();
    int r0 = resp_cnt;
    burst(32'h0000_9010, 32'h0000_9010, 32'h0A0B_0C0D, 2, -1, 1, 0);
    wait_resp(r0 + 1);
    tick(2);
    burst(32'h0000_A020, 32'h0000_A020, 32'h1357_9BDF, 6, -1, 0, 0);
    wait_resp(r0 + 2);
  endtask

  task automatic test_busy_back_to_back();
    int r0  = resp_cnt;
    int ar0 = ar_cnt;
    tick(2);
    send_req(32'h0000_B000);
    ar_phase(32'h0000_B000, 0);
    send_beat(32'hB000_0000, AXI_RESP_OKAY, 1'b0);
    send_beat(32'hB000_0001, AXI_RESP_OKAY, 1'b0);
    req_if.read_req_valid = 1'b1;
    req_if.read_addr      = 32'h0000_C000;
    tick();
    req_if.read_req_valid = 1'b0;
    send_beat(32'hB000_0002, AXI_RESP_OKAY, 1'b0);
    send_beat(32'hB000_0003, AXI_RESP_OKAY, 1'b1);
    // Now in the response cycle: a request here must be ignored.
    req_if.read_req_valid = 1'b1;
    req_if.read_addr      = 32'h0000_D000;
    tick();
    req_if.read_req_valid = 1'b0;
    checks++;
    if (axi_if.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL resp_req_ignored: arvalid=%b required 0", axi_if.arvalid);
    end
    checks++;
    if (ar_cnt - ar0 !== 1) begin
      failures++;
      $display("FAIL busy_single_ar: got %0d AR handshakes required 1", ar_cnt - ar0);
    end
    send_req(32'h0000_E004);
    checks++;
    if (axi_if.arvalid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ar: arvalid=%b required 1 one cycle after request", axi_if.arvalid);
    end
    ar_phase(32'h0000_E000, 0);
    for (int i = 0; i < BEATS; i++)
      send_beat(DW'(32'hE000_0000 + i), AXI_RESP_OKAY, i == BEATS - 1);
    wait_resp(r0 + 2);
  endtask

  task automatic test_reset_mid_burst();
    int r0 = resp_cnt;
    tick(2);
    send_req(32'h0000_F000);
    ar_phase(32'h0000_F000, 0);
    send_beat(32'hF000_0000, AXI_RESP_OKAY, 1'b0);
    send_beat(32'hF000_0001, AXI_RESP_OKAY, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axi_if.arvalid, axi_if.rready, req_if.read_resp_valid, req_if.read_err} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got arvalid,rready,resp,err=%b required 0000",
               {axi_if.arvalid, axi_if.rready, req_if.read_resp_valid, req_if.read_err});
    end
    tick(2);
    rst_n = 1'b1;
    tick();
    burst(32'h0000_F100, 32'h0000_F100, 32'h0A0A_0A0A, 4, -1, 0, 0);
    wait_resp(r0 + 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error_resp();
    test_length_mismatch();
    test_busy_back_to_back();
    test_reset_mid_burst();
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    checks++;
    if (resp_cnt !== 8) begin
      failures++;
      $display("FAIL total_resp: got %0d pulses required 8", resp_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
